i2c_slave_responder: RTL and testbench

I2C target (slave) endpoint: the far end of the bus from the WISHBONE I2C master controller. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, and moves bytes to and from a local byte-wide handshake interface. Holds SCL low (clock stretching) while waiting for read data from the local side. Uses the same open-drain pad convention as the master: `*_pad_o` is tied 0, and `*_padoen_o` low drives the line.

---
 rtl/i2c_slave_responder.sv | 183 ++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target endpoint with 7-bit address match, byte write
// delivery, and clock-stretched byte reads from a local handshake interface.
module i2c_slave_responder #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       wb_clk_i,
   input  logic       arst_i,
   input  logic       scl_pad_i,
   input  logic       sda_pad_i,
   output logic       scl_pad_o,
   output logic       scl_padoen_o,
   output logic       sda_pad_o,
   output logic       sda_padoen_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       tx_req_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       busy_o
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_WAIT, RD_DATA, RD_ACK, IGNORE
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] scl_sync, sda_sync;
   logic       scl_prev, sda_prev;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] sh, sh_nxt, rx_data, rx_data_nxt, shifted;
   logic       rw, rw_nxt, sda_drv, sda_drv_nxt, scl_hold, scl_hold_nxt;
   logic       rx_pend, rx_pend_nxt, rx_valid, rx_valid_nxt, tx_req, tx_req_nxt;
   logic       scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s & scl_prev;
   assign sda_rise  = sda_s & ~sda_prev;
   assign sda_fall  = ~sda_s & sda_prev;
   assign start_det = sda_fall & scl_s;
   assign stop_det  = sda_rise & scl_s;
   assign shifted   = {sh[6:0], sda_s};

   assign scl_pad_o    = 1'b0;
   assign sda_pad_o    = 1'b0;
   assign scl_padoen_o = ~scl_hold;
   assign sda_padoen_o = ~sda_drv;
   assign rx_data_o    = rx_data;
   assign rx_valid_o   = rx_valid;
   assign tx_req_o     = tx_req;
   assign busy_o       = (state != IDLE);

   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
         state    <= IDLE;
         cnt      <= 4'd0;
         sh       <= 8'h00;
         rw       <= 1'b0;
         sda_drv  <= 1'b0;
         scl_hold <= 1'b0;
         rx_data  <= 8'h00;
         rx_pend  <= 1'b0;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
      end else begin
         scl_sync <= {scl_sync[0], scl_pad_i};
         sda_sync <= {sda_sync[0], sda_pad_i};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         sh       <= sh_nxt;
         rw       <= rw_nxt;
         sda_drv  <= sda_drv_nxt;
         scl_hold <= scl_hold_nxt;
         rx_data  <= rx_data_nxt;
         rx_pend  <= rx_pend_nxt;
         rx_valid <= rx_valid_nxt;
         tx_req   <= tx_req_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      sh_nxt       = sh;
      rw_nxt       = rw;
      sda_drv_nxt  = sda_drv;
      scl_hold_nxt = scl_hold;
      rx_data_nxt  = rx_data;
      rx_pend_nxt  = 1'b0;
      rx_valid_nxt = rx_pend;
      tx_req_nxt   = 1'b0;
      if (stop_det) begin
         state_nxt    = IDLE;
         cnt_nxt      = 4'd0;
         sda_drv_nxt  = 1'b0;
         scl_hold_nxt = 1'b0;
      end else if (start_det) begin
         state_nxt    = ADDR;
         cnt_nxt      = 4'd0;
         sda_drv_nxt  = 1'b0;
         scl_hold_nxt = 1'b0;
      end else begin
         case (state)
            ADDR: if (scl_rise) begin
               sh_nxt  = shifted;
               cnt_nxt = cnt + 4'd1;
               if (cnt == 4'd7) begin
                  rw_nxt    = sda_s;
                  // address 0 (general call) is never answered
                  state_nxt = (shifted[7:1] == SLAVE_ADDR && shifted[7:1] != 7'd0) ? ADDR_ACK : IGNORE;
               end
            end
            ADDR_ACK, WR_ACK: begin
               if (scl_rise)
                  cnt_nxt = cnt + 4'd1;
               else if (scl_fall && cnt == 4'd8)
                  sda_drv_nxt = 1'b1;
               else if (scl_fall && cnt == 4'd9) begin
                  sda_drv_nxt = 1'b0;
                  cnt_nxt     = 4'd0;
                  if (state == WR_ACK || !rw)
                     state_nxt = WR_DATA;
                  else begin
                     state_nxt    = RD_WAIT;
                     tx_req_nxt   = 1'b1;
                     scl_hold_nxt = 1'b1;
                  end
               end
            end
            WR_DATA: if (scl_rise) begin
               sh_nxt  = shifted;
               cnt_nxt = cnt + 4'd1;
               if (cnt == 4'd7) begin
                  rx_data_nxt = shifted;
                  rx_pend_nxt = 1'b1;
                  state_nxt   = WR_ACK;
               end
            end
            RD_WAIT: begin
               cnt_nxt      = 4'd0;
               scl_hold_nxt = 1'b1;
               if (tx_valid_i) begin
                  sh_nxt      = tx_data_i;
                  sda_drv_nxt = ~tx_data_i[7];
                  state_nxt   = RD_DATA;
               end
            end
            RD_DATA: begin
               // SCL is released one cycle after the first bit is on SDA
               scl_hold_nxt = 1'b0;
               if (scl_rise)
                  cnt_nxt = cnt + 4'd1;
               else if (scl_fall && cnt == 4'd8) begin
                  sda_drv_nxt = 1'b0;
                  state_nxt   = RD_ACK;
               end else if (scl_fall && cnt != 4'd0) begin
                  sh_nxt      = {sh[6:0], 1'b0};
                  sda_drv_nxt = ~sh[6];
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  cnt_nxt = cnt + 4'd1;
                  if (sda_s)
                     state_nxt = IGNORE;
               end else if (scl_fall && cnt == 4'd9) begin
                  cnt_nxt      = 4'd0;
                  state_nxt    = RD_WAIT;
                  tx_req_nxt   = 1'b1;
                  scl_hold_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: directed I2C master model driving the target through
// write, read, repeated-start, stop and reset scenarios.
module tb_i2c_slave_responder;
   logic       clk = 1'b0;
   logic       arst, scl_m, sda_m, tx_valid;
   logic [7:0] tx_data;
   logic       scl_line, sda_line;
   logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o, rx_valid_o, tx_req_o, busy_o;
   logic [7:0] rx_data_o;
   int         total = 0, bad = 0;
   int         rx_cnt = 0, req_cnt = 0, stretch_cnt = 0, sda_low_cnt = 0;
   int         resp_delay = 0;
   logic [7:0] rx_log [0:7];
   logic [7:0] resp_data [0:3];

   always #5 clk = ~clk;

   assign scl_line = scl_m & scl_padoen_o;
   assign sda_line = sda_m & sda_padoen_o;

   i2c_slave_responder #(.SLAVE_ADDR(7'h50)) dut (
      .wb_clk_i(clk), .arst_i(arst),
      .scl_pad_i(scl_line), .sda_pad_i(sda_line),
      .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
      .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .tx_req_o(tx_req_o), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
      .busy_o(busy_o)
   );

   always @(negedge clk) begin
      if (rx_valid_o) begin
         rx_log[rx_cnt % 8] = rx_data_o;
         rx_cnt++;
      end
      if (scl_padoen_o === 1'b0) stretch_cnt++;
      if (sda_padoen_o === 1'b0) sda_low_cnt++;
   end

   // local side: answer each read request after resp_delay cycles
   initial begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (tx_req_o === 1'b1) begin
            tx_data = resp_data[req_cnt % 4];
            req_cnt++;
            repeat (resp_delay) @(negedge clk);
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000ns");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_scl_high();
      int i;
      i = 0;
      while (scl_line !== 1'b1 && i < 2000) begin
         @(negedge clk);
         i++;
      end
      total++;
      if (scl_line !== 1'b1) begin
         bad++;
         $display("FAIL scl_release: scl=%b required 1", scl_line);
      end
   endtask

   task automatic bus_start();
      sda_m = 1'b1; tick(5);
      scl_m = 1'b1; wait_scl_high(); tick(10);
      sda_m = 1'b0; tick(10);
      scl_m = 1'b0; tick(5);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(5);
      scl_m = 1'b1; wait_scl_high(); tick(10);
      sda_m = 1'b1; tick(10);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; tick(5);
      scl_m = 1'b1; wait_scl_high(); tick(10);
      scl_m = 1'b0; tick(5);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; tick(5);
      scl_m = 1'b1; wait_scl_high(); tick(5);
      b = sda_line; tick(5);
      scl_m = 1'b0; tick(5);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(ack);
   endtask

   task automatic test_reset();
      arst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
      tick(3);
      total += 8;
      if (scl_padoen_o !== 1'b1) begin bad++; $display("FAIL reset_scl_padoen: got %b exp 1", scl_padoen_o); end
      if (sda_padoen_o !== 1'b1) begin bad++; $display("FAIL reset_sda_padoen: got %b exp 1", sda_padoen_o); end
      if (scl_pad_o !== 1'b0) begin bad++; $display("FAIL reset_scl_pad: got %b exp 0", scl_pad_o); end
      if (sda_pad_o !== 1'b0) begin bad++; $display("FAIL reset_sda_pad: got %b exp 0", sda_pad_o); end
      if (rx_data_o !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h exp 00", rx_data_o); end
      if (rx_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b exp 0", rx_valid_o); end
      if (tx_req_o !== 1'b0) begin bad++; $display("FAIL reset_tx_req: got %b exp 0", tx_req_o); end
      if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
      arst = 1'b1;
      tick(5);
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b exp 0", busy_o); end
   endtask

   task automatic test_addr_mismatch();
      int base_low, base_rx;
      logic a0, a1;
      base_low = sda_low_cnt; base_rx = rx_cnt;
      bus_start();
      total++;
      if (busy_o !== 1'b1) begin bad++; $display("FAIL mismatch_busy_start: got %b exp 1", busy_o); end
      write_byte(8'hA2, a0);
      write_byte(8'h12, a1);
      total += 4;
      if (a0 !== 1'b1) begin bad++; $display("FAIL mismatch_addr_ack: got %b exp 1", a0); end
      if (a1 !== 1'b1) begin bad++; $display("FAIL mismatch_data_ack: got %b exp 1", a1); end
      if (sda_low_cnt != base_low) begin bad++; $display("FAIL mismatch_sda_driven: got %0d cycles exp 0", sda_low_cnt - base_low); end
      if (rx_cnt != base_rx) begin bad++; $display("FAIL mismatch_rx_valid: got %0d exp 0", rx_cnt - base_rx); end
      bus_stop(); tick(5);
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL mismatch_busy_stop: got %b exp 0", busy_o); end
   endtask

   task automatic test_write_two();
      int base_rx;
      logic a0, a1, a2;
      base_rx = rx_cnt;
      bus_start();
      write_byte(8'hA0, a0);
      write_byte(8'h3C, a1);
      write_byte(8'hC5, a2);
      bus_stop(); tick(5);
      total += 7;
      if (a0 !== 1'b0) begin bad++; $display("FAIL write_addr_ack: got %b exp 0", a0); end
      if (a1 !== 1'b0) begin bad++; $display("FAIL write_byte1_ack: got %b exp 0", a1); end
      if (a2 !== 1'b0) begin bad++; $display("FAIL write_byte2_ack: got %b exp 0", a2); end
      if (rx_cnt - base_rx != 2) begin bad++; $display("FAIL write_rx_count: got %0d exp 2", rx_cnt - base_rx); end
      if (rx_log[base_rx % 8] !== 8'h3C) begin bad++; $display("FAIL write_rx0: got %h exp 3c", rx_log[base_rx % 8]); end
      if (rx_log[(base_rx + 1) % 8] !== 8'hC5) begin bad++; $display("FAIL write_rx1: got %h exp c5", rx_log[(base_rx + 1) % 8]); end
      if (busy_o !== 1'b0) begin bad++; $display("FAIL write_busy_stop: got %b exp 0", busy_o); end
   endtask

   task automatic test_read_stretch();
      int base_req, base_st, st;
      logic a;
      logic [7:0] d;
      resp_delay = 20;
      resp_data[req_cnt % 4] = 8'h96;
      base_req = req_cnt; base_st = stretch_cnt;
      bus_start();
      write_byte(8'hA1, a);
      read_byte(1'b1, d);
      st = stretch_cnt - base_st;
      tick(60);
      total += 4;
      if (a !== 1'b0) begin bad++; $display("FAIL read_addr_ack: got %b exp 0", a); end
      if (d !== 8'h96) begin bad++; $display("FAIL read_data: got %h exp 96", d); end
      if (st < 20 || st > 24) begin bad++; $display("FAIL read_stretch_len: got %0d exp 20..24", st); end
      if (req_cnt - base_req != 1) begin bad++; $display("FAIL read_req_count: got %0d exp 1", req_cnt - base_req); end
      bus_stop(); tick(5);
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL read_busy_stop: got %b exp 0", busy_o); end
   endtask

   task automatic test_repeated_start();
      int base_req, base_rx;
      logic a0, a1, a2;
      logic [7:0] d0, d1;
      resp_delay = 3;
      resp_data[req_cnt % 4] = 8'hAA;
      resp_data[(req_cnt + 1) % 4] = 8'h55;
      base_req = req_cnt; base_rx = rx_cnt;
      bus_start();
      write_byte(8'hA0, a0);
      write_byte(8'h01, a1);
      bus_start();
      write_byte(8'hA1, a2);
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      tick(40);
      bus_stop(); tick(5);
      total += 8;
      if (a0 !== 1'b0) begin bad++; $display("FAIL rs_addr_ack: got %b exp 0", a0); end
      if (a1 !== 1'b0) begin bad++; $display("FAIL rs_data_ack: got %b exp 0", a1); end
      if (a2 !== 1'b0) begin bad++; $display("FAIL rs_raddr_ack: got %b exp 0", a2); end
      if (d0 !== 8'hAA) begin bad++; $display("FAIL rs_read0: got %h exp aa", d0); end
      if (d1 !== 8'h55) begin bad++; $display("FAIL rs_read1: got %h exp 55", d1); end
      if (req_cnt - base_req != 2) begin bad++; $display("FAIL rs_req_count: got %0d exp 2", req_cnt - base_req); end
      if (rx_cnt - base_rx != 1) begin bad++; $display("FAIL rs_rx_count: got %0d exp 1", rx_cnt - base_rx); end
      if (rx_log[base_rx % 8] !== 8'h01) begin bad++; $display("FAIL rs_rx_data: got %h exp 01", rx_log[base_rx % 8]); end
   endtask

   task automatic test_stop_mid_byte();
      int base_rx;
      logic a0, a1, a2;
      base_rx = rx_cnt;
      bus_start();
      write_byte(8'hA0, a0);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
      bus_stop(); tick(5);
      total += 5;
      if (a0 !== 1'b0) begin bad++; $display("FAIL smb_addr_ack: got %b exp 0", a0); end
      if (rx_cnt != base_rx) begin bad++; $display("FAIL smb_rx_valid: got %0d exp 0", rx_cnt - base_rx); end
      if (busy_o !== 1'b0) begin bad++; $display("FAIL smb_busy: got %b exp 0", busy_o); end
      if (scl_padoen_o !== 1'b1) begin bad++; $display("FAIL smb_scl_padoen: got %b exp 1", scl_padoen_o); end
      if (sda_padoen_o !== 1'b1) begin bad++; $display("FAIL smb_sda_padoen: got %b exp 1", sda_padoen_o); end
      bus_start();
      write_byte(8'hA0, a1);
      write_byte(8'h77, a2);
      bus_stop(); tick(5);
      total += 3;
      if (a2 !== 1'b0) begin bad++; $display("FAIL smb_next_ack: got %b exp 0", a2); end
      if (rx_cnt - base_rx != 1) begin bad++; $display("FAIL smb_next_count: got %0d exp 1", rx_cnt - base_rx); end
      if (rx_log[base_rx % 8] !== 8'h77) begin bad++; $display("FAIL smb_next_data: got %h exp 77", rx_log[base_rx % 8]); end
   endtask

   task automatic test_reset_mid_read();
      int base_req, base_rx;
      logic a0, a1;
      resp_delay = 300;
      base_req = req_cnt;
      bus_start();
      write_byte(8'hA1, a0);
      tick(20);
      total += 3;
      if (a0 !== 1'b0) begin bad++; $display("FAIL rmr_addr_ack: got %b exp 0", a0); end
      if (scl_padoen_o !== 1'b0) begin bad++; $display("FAIL rmr_stretch: got %b exp 0", scl_padoen_o); end
      if (req_cnt - base_req != 1) begin bad++; $display("FAIL rmr_req_count: got %0d exp 1", req_cnt - base_req); end
      #2 arst = 1'b0;
      #1;
      total += 4;
      if (scl_padoen_o !== 1'b1) begin bad++; $display("FAIL rmr_scl_released: got %b exp 1", scl_padoen_o); end
      if (sda_padoen_o !== 1'b1) begin bad++; $display("FAIL rmr_sda_released: got %b exp 1", sda_padoen_o); end
      if (busy_o !== 1'b0) begin bad++; $display("FAIL rmr_busy: got %b exp 0", busy_o); end
      if (tx_req_o !== 1'b0) begin bad++; $display("FAIL rmr_tx_req: got %b exp 0", tx_req_o); end
      tick(5);
      arst = 1'b1;
      tick(5);
      base_rx = rx_cnt;
      bus_start();
      write_byte(8'hA0, a1);
      bus_stop();
      tick(350);
      total += 3;
      if (a1 !== 1'b0) begin bad++; $display("FAIL rmr_new_ack: got %b exp 0", a1); end
      if (busy_o !== 1'b0) begin bad++; $display("FAIL rmr_end_busy: got %b exp 0", busy_o); end
      if (rx_cnt != base_rx) begin bad++; $display("FAIL rmr_rx_valid: got %0d exp 0", rx_cnt - base_rx); end
   endtask

   initial begin
      arst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
      for (int i = 0; i < 4; i++) resp_data[i] = 8'h00;
      test_reset();
      test_addr_mismatch();
      test_write_two();
      test_read_stretch();
      test_repeated_start();
      test_stop_mid_byte();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
